print_arbiter: RTL and testbench
================================

Name: print_arbiter

Overview:
- Shares one print/console device between two requesters (e.g. instruction fetch and data port, or two harts).
- Accepts single-cycle valid pulses on either requester port and buffers one pending request per port.
- Issues exactly one single-cycle valid pulse per transaction to the device, because the device emits a character on every cycle its valid is high.
- Returns the device response to the granted requester; round-robin fairness.

Parameters:
TIMEOUT, 255, cycles waited for print_ready before forced completion (PRINT_TIMEOUT_EN only)
ERR_DATA, 32'hDEADBEEF, rdata returned on timeout (PRINT_TIMEOUT_EN only)

Ports:
reset  input  1  asynchronous, active-high reset
clock  input  1  single clock, rising edge
req0_valid  input  1  requester 0 request pulse (one cycle)
req0_instr  input  1  requester 0 instruction-access flag
req0_addr  input  32  requester 0 address
req0_wdata  input  32  requester 0 write data (char in [7:0])
req0_wstrb  input  4  requester 0 byte strobes
req0_rdata  output  32  requester 0 read data
req0_ready  output  1  requester 0 completion pulse
req1_*  (same seven signals, same widths/directions) for requester 1
print_valid  output  1  device request pulse
print_instr  output  1  forwarded instr flag
print_addr  output  32  forwarded address
print_wdata  output  32  forwarded write data
print_wstrb  output  4  forwarded strobes
print_rdata  input  32  device read data
print_ready  input  1  device completion pulse

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; pend0 = pend1 = 0; priority pointer = 0; timeout counter = 0.
- All outputs registered; reqN_ready and print_valid are one-cycle pulses.
- Capture: reqN_valid = 1 while the port is neither pending nor granted -> latch instr/addr/wdata/wstrb into port N buffer and set pendN at the clock edge.
- Protocol rule: a requester issues no new valid until its ready. A valid on a port that is already pending or granted is ignored; buffer is not overwritten.
- IDLE:
  - Candidates = pendN OR reqN_valid (an incoming valid counts in the same cycle; it bypasses the buffer).
  - One candidate -> grant it. Both -> grant the port equal to the priority pointer.
  - At the edge: print_valid <= 1 and print_* <= granted fields; clear the granted pend bit; state -> WAIT.
  - A non-granted incoming valid in the same cycle is captured into its buffer.
- WAIT:
  - print_valid <= 0 after its single cycle.
  - print_ready = 1 -> at the edge: reqG_rdata <= print_rdata, reqG_ready <= 1, pointer <= other port, state -> IDLE.
  - print_ready during IDLE is ignored.
- Latency, idle arbiter: req valid in cycle t; print_valid in t+1; device ready in t+2 (registered device); req ready in t+3.
- Back-to-back: the other pending port gets print_valid in t+4, i.e. one IDLE cycle between grants.
- reqN_rdata holds its last value until the next completion on that port; reqN_ready is 0 otherwise.
- Reset mid-transaction: everything is cleared; pending and in-flight requests are lost with no ready returned.

Optional Feature:
- Macro: PRINT_TIMEOUT_EN.
- With the macro:
  - In WAIT a counter increments each cycle; it is cleared on entry to WAIT.
  - If the counter reaches TIMEOUT with no print_ready, complete anyway: reqG_rdata <= ERR_DATA, reqG_ready <= 1, pointer rotates, state -> IDLE.
  - A late print_ready arriving in IDLE is ignored.
- Without the macro: no counter logic; WAIT lasts until print_ready, with no bound.

Test Plan:
- Single request: req0_valid pulse, wdata=32'h41, wstrb=4'h1. Expect one print_valid pulse in t+1 with print_wdata=32'h41. Device ready in t+2 with rdata=0. Expect req0_ready pulse in t+3, req0_rdata=0; req1_ready stays 0.
- Simultaneous: req0 'A' and req1 'B' in the same cycle after reset. Expect 'A' first (pointer=0), then 'B' with print_valid 4 cycles later. Exactly two print_valid pulses; each ready goes to the correct port.
- Fairness: hold both requesters re-requesting immediately after each ready for 8 rounds. Expect grants to strictly alternate 0,1,0,1,...
- Stall: device delays print_ready by 10 cycles. Expect print_valid high for exactly 1 cycle and req ready 1 cycle after print_ready. A req1 valid during the stall is buffered and served next.
- Async reset asserted mid-WAIT with req1 pending. Expect all outputs 0 immediately; after release, no print_valid until a new request arrives.
- PRINT_TIMEOUT_EN, TIMEOUT=16: device never readies. Expect req0_ready with rdata=32'hDEADBEEF 16 cycles after entering WAIT; arbiter then serves req1 normally.

Source files
------------

// File: rtl/print_arbiter_if.sv
// rtl/print_arbiter_if.sv - requester and device signal bundle for print_arbiter
// Purpose: groups both requester ports and the print device port into one bundle.
// Ports:   req0_*/req1_* - valid/instr/addr/wdata/wstrb towards the arbiter,
//                          rdata/ready back to the requester
//          print_*       - valid/instr/addr/wdata/wstrb towards the device,
//                          rdata/ready back from the device
// Modports: slave  - arbiter side
//           master - requester/device side
interface print_arbiter_if;
   logic        req0_valid;
   logic        req0_instr;
   logic [31:0] req0_addr;
   logic [31:0] req0_wdata;
   logic [3:0]  req0_wstrb;
   logic [31:0] req0_rdata;
   logic        req0_ready;

   logic        req1_valid;
   logic        req1_instr;
   logic [31:0] req1_addr;
   logic [31:0] req1_wdata;
   logic [3:0]  req1_wstrb;
   logic [31:0] req1_rdata;
   logic        req1_ready;

   logic        print_valid;
   logic        print_instr;
   logic [31:0] print_addr;
   logic [31:0] print_wdata;
   logic [3:0]  print_wstrb;
   logic [31:0] print_rdata;
   logic        print_ready;

   modport slave (
      input  req0_valid, req0_instr, req0_addr, req0_wdata, req0_wstrb,
      output req0_rdata, req0_ready,
      input  req1_valid, req1_instr, req1_addr, req1_wdata, req1_wstrb,
      output req1_rdata, req1_ready,
      output print_valid, print_instr, print_addr, print_wdata, print_wstrb,
      input  print_rdata, print_ready
   );

   modport master (
      output req0_valid, req0_instr, req0_addr, req0_wdata, req0_wstrb,
      input  req0_rdata, req0_ready,
      output req1_valid, req1_instr, req1_addr, req1_wdata, req1_wstrb,
      input  req1_rdata, req1_ready,
      input  print_valid, print_instr, print_addr, print_wdata, print_wstrb,
      output print_rdata, print_ready
   );
endinterface

// File: rtl/print_arbiter.sv
// rtl/print_arbiter.sv - two-port round-robin arbiter in front of one print device
// Purpose: buffers one request per requester, forwards exactly one single-cycle
//          print_valid per transaction and routes the device response back to
//          the granted requester. Grants alternate when both ports compete.
// Ports:   clock - rising-edge clock
//          reset - asynchronous active-high reset
//          bus   - print_arbiter_if.slave (req0_*, req1_*, print_*)
// Option:  PRINT_TIMEOUT_EN - bounds the wait for print_ready to TIMEOUT cycles;
//          on expiry the requester is completed with ERR_DATA.
module print_arbiter
`ifdef PRINT_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
)
`endif
(
   input  logic           clock,
   input  logic           reset,
   print_arbiter_if.slave bus
);

   typedef struct packed {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } fields_t;

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        pend0_q, pend0_d, pend1_q, pend1_d;
   logic        gnt_q, gnt_d;            // port owning the transaction in WAIT
   logic        ptr_q, ptr_d;            // preferred port on a tie
   fields_t     buf0_q, buf0_d, buf1_q, buf1_d;
   fields_t     print_q, print_d;
   logic        print_valid_q, print_valid_d;
   logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic        ready0_q, ready0_d, ready1_q, ready1_d;

   fields_t     in0, in1;
   logic        cand0, cand1, grant_sel, idle_grant, busy0, busy1, done;
   logic [31:0] done_data;

   assign in0 = {bus.req0_instr, bus.req0_addr, bus.req0_wdata, bus.req0_wstrb};
   assign in1 = {bus.req1_instr, bus.req1_addr, bus.req1_wdata, bus.req1_wstrb};

   // An incoming valid competes in the same cycle as a buffered one.
   assign cand0      = pend0_q | bus.req0_valid;
   assign cand1      = pend1_q | bus.req1_valid;
   assign grant_sel  = (cand0 && cand1) ? ptr_q : cand1;
   assign idle_grant = (state_q == S_IDLE) && (cand0 || cand1);

   // A port that is pending or in flight ignores further valids.
   assign busy0 = pend0_q || ((state_q == S_WAIT) && !gnt_q);
   assign busy1 = pend1_q || ((state_q == S_WAIT) &&  gnt_q);

`ifdef PRINT_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_hit;

   // Counter is held at zero outside WAIT, so it starts from zero on entry.
   assign cnt_d       = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
   assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT - 1));
   assign done        = (state_q == S_WAIT) && (bus.print_ready || timeout_hit);
   assign done_data   = bus.print_ready ? bus.print_rdata : ERR_DATA;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign done      = (state_q == S_WAIT) && bus.print_ready;
   assign done_data = bus.print_rdata;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (idle_grant) state_d = S_WAIT;
         S_WAIT:  if (done)       state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pend0_d       = pend0_q;
      pend1_d       = pend1_q;
      buf0_d        = buf0_q;
      buf1_d        = buf1_q;
      gnt_d         = gnt_q;
      ptr_d         = ptr_q;
      print_d       = print_q;
      print_valid_d = 1'b0;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
      ready0_d      = 1'b0;
      ready1_d      = 1'b0;

      // Capture unless the valid is being granted directly this cycle.
      if (bus.req0_valid && !busy0 && !(idle_grant && !grant_sel)) begin
         buf0_d  = in0;
         pend0_d = 1'b1;
      end
      if (bus.req1_valid && !busy1 && !(idle_grant && grant_sel)) begin
         buf1_d  = in1;
         pend1_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (idle_grant) begin
               print_valid_d = 1'b1;
               gnt_d         = grant_sel;
               if (!grant_sel) begin
                  print_d = pend0_q ? buf0_q : in0;
                  pend0_d = 1'b0;
               end else begin
                  print_d = pend1_q ? buf1_q : in1;
                  pend1_d = 1'b0;
               end
            end
         end
         S_WAIT: begin
            if (done) begin
               ptr_d = ~gnt_q;
               if (!gnt_q) begin
                  rdata0_d = done_data;
                  ready0_d = 1'b1;
               end else begin
                  rdata1_d = done_data;
                  ready1_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pend0_q       <= 1'b0;
         pend1_q       <= 1'b0;
         buf0_q        <= '0;
         buf1_q        <= '0;
         gnt_q         <= 1'b0;
         ptr_q         <= 1'b0;
         print_q       <= '0;
         print_valid_q <= 1'b0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
         ready0_q      <= 1'b0;
         ready1_q      <= 1'b0;
      end else begin
         pend0_q       <= pend0_d;
         pend1_q       <= pend1_d;
         buf0_q        <= buf0_d;
         buf1_q        <= buf1_d;
         gnt_q         <= gnt_d;
         ptr_q         <= ptr_d;
         print_q       <= print_d;
         print_valid_q <= print_valid_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
         ready0_q      <= ready0_d;
         ready1_q      <= ready1_d;
      end
   end

   assign bus.print_valid = print_valid_q;
   assign bus.print_instr = print_q.instr;
   assign bus.print_addr  = print_q.addr;
   assign bus.print_wdata = print_q.wdata;
   assign bus.print_wstrb = print_q.wstrb;
   assign bus.req0_rdata  = rdata0_q;
   assign bus.req0_ready  = ready0_q;
   assign bus.req1_rdata  = rdata1_q;
   assign bus.req1_ready  = ready1_q;

endmodule

// File: tb/tb_print_arbiter.sv
// tb/tb_print_arbiter.sv - randomized self-checking bench for print_arbiter
module tb_print_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   print_arbiter_if bus();

`ifdef PRINT_TIMEOUT_EN
   localparam int TB_TIMEOUT = 16;
   print_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (.clock(clock), .reset(reset), .bus(bus));
`else
   print_arbiter dut (.clock(clock), .reset(reset), .bus(bus));
`endif

   typedef struct {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Transaction-level model: which requests wait, which one is at the device,
   // who wins the next tie, and when the device answers.
   req_t        reqs[2];
   bit          waiting[2];
   bit          outstanding[2];
   int          infl;
   int          ptr;
   bit          idle;
   int          pv_cycle;
   int          rdy_cycle;
   logic [31:0] dev_rdata;
   logic [31:0] last_rdata[2];

   int unsigned p_req;
   int unsigned dmin, dmax;
   bit          never;
   bit          garbage_en;
   bit          force_req[2];
   req_t        forced[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin
         waiting[n]     = 1'b0;
         outstanding[n] = 1'b0;
         last_rdata[n]  = '0;
         force_req[n]   = 1'b0;
      end
      infl      = -1;
      ptr       = 0;
      idle      = 1'b1;
      rdy_cycle = -1;
      pv_cycle  = 0;
   endtask

   task automatic drive_port(input int n, input bit v, input req_t f);
      if (n == 0) begin
         bus.req0_valid = v; bus.req0_instr = f.instr; bus.req0_addr = f.addr;
         bus.req0_wdata = f.wdata; bus.req0_wstrb = f.wstrb;
      end else begin
         bus.req1_valid = v; bus.req1_instr = f.instr; bus.req1_addr = f.addr;
         bus.req1_wdata = f.wdata; bus.req1_wstrb = f.wstrb;
      end
   endtask

   task automatic drive_idle();
      req_t z;
      z = '{1'b0, 32'd0, 32'd0, 4'd0};
      drive_port(0, 1'b0, z);
      drive_port(1, 1'b0, z);
      bus.print_ready = 1'b0;
      bus.print_rdata = '0;
   endtask

   // Asynchronous reset away from any clock edge; outputs must clear at once.
   task automatic do_reset();
      #2 reset = 1'b1;
      drive_idle();
      #1 check("reset_outputs",
               32'(|{bus.req0_rdata, bus.req0_ready, bus.req1_rdata, bus.req1_ready,
                     bus.print_valid, bus.print_instr, bus.print_addr,
                     bus.print_wdata, bus.print_wstrb}), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   // One cycle: observe the outputs of the last edge, then drive the next inputs.
   task automatic step();
      bit          exp_pv;
      int          exp_port;
      int          rdy_port;
      logic [31:0] rdy_data;
      req_t        r;
      @(negedge clock);
      cyc++;
      exp_pv   = idle && (waiting[0] || waiting[1]);
      exp_port = (waiting[0] && waiting[1]) ? ptr : (waiting[1] ? 1 : 0);
      rdy_port = -1;
      rdy_data = '0;
      if (infl >= 0) begin
         if (rdy_cycle >= 0 && cyc == rdy_cycle + 1) begin
            rdy_port = infl;
            rdy_data = dev_rdata;
         end
`ifdef PRINT_TIMEOUT_EN
         else if (cyc == pv_cycle + TB_TIMEOUT) begin
            rdy_port = infl;
            rdy_data = 32'hDEADBEEF;
         end
`endif
      end

      check("print_valid", 32'(bus.print_valid), 32'(exp_pv));
      if (exp_pv) begin
         r = reqs[exp_port];
         check("print_instr", 32'(bus.print_instr), 32'(r.instr));
         check("print_addr",  bus.print_addr,  r.addr);
         check("print_wdata", bus.print_wdata, r.wdata);
         check("print_wstrb", 32'(bus.print_wstrb), 32'(r.wstrb));
         waiting[exp_port] = 1'b0;
         infl      = exp_port;
         idle      = 1'b0;
         pv_cycle  = cyc;
         rdy_cycle = never ? -1 : cyc + int'($urandom_range(dmax, dmin));
         dev_rdata = $urandom;
      end

      check("req0_ready", 32'(bus.req0_ready), 32'(rdy_port == 0));
      check("req1_ready", 32'(bus.req1_ready), 32'(rdy_port == 1));
      if (rdy_port >= 0) begin
         last_rdata[rdy_port]  = rdy_data;
         outstanding[rdy_port] = 1'b0;
         ptr       = 1 - rdy_port;
         infl      = -1;
         idle      = 1'b1;
         rdy_cycle = -1;
      end
      check("req0_rdata", bus.req0_rdata, last_rdata[0]);
      check("req1_rdata", bus.req1_rdata, last_rdata[1]);

      // Device side; a stray ready while the arbiter idles must be ignored.
      bus.print_ready = (rdy_cycle >= 0 && cyc == rdy_cycle);
      bus.print_rdata = bus.print_ready ? dev_rdata : $urandom;
      if (!bus.print_ready && idle && $urandom_range(9, 0) == 0) bus.print_ready = 1'b1;

      // Requesters; a busy port occasionally sends a protocol-violating valid.
      for (int n = 0; n < 2; n++) begin
         req_t f;
         bit   v;
         f.instr = 1'($urandom);
         f.addr  = $urandom;
         f.wdata = $urandom;
         f.wstrb = 4'($urandom);
         v = 1'b0;
         if (!outstanding[n] && (force_req[n] || $urandom_range(99, 0) < p_req)) begin
            if (force_req[n]) f = forced[n];
            reqs[n]        = f;
            waiting[n]     = 1'b1;
            outstanding[n] = 1'b1;
            v = 1'b1;
         end else if (outstanding[n] && garbage_en && $urandom_range(7, 0) == 0) begin
            v = 1'b1;
         end
         drive_port(n, v, f);
         force_req[n] = 1'b0;
      end
   endtask

   initial begin
      drive_idle();
      model_reset();
      p_req = 0; dmin = 1; dmax = 1; never = 1'b0; garbage_en = 1'b0;
      do_reset();

      // Single request, registered device answering one cycle after print_valid.
      forced[0] = '{1'b0, 32'h1000_0000, 32'h0000_0041, 4'h1};
      force_req[0] = 1'b1;
      repeat (8) step();

      // Simultaneous requests straight after reset: port 0 wins first.
      do_reset();
      forced[0] = '{1'b0, 32'h1000_0000, 32'h0000_0041, 4'h1};
      forced[1] = '{1'b1, 32'h1000_0004, 32'h0000_0042, 4'h1};
      force_req[0] = 1'b1;
      force_req[1] = 1'b1;
      repeat (12) step();

      // Fairness: both ports re-request immediately after every ready.
      p_req = 100; dmin = 1; dmax = 3;
      repeat (48) step();

      // Stall: long device latency, req1 arrives mid-stall.
      p_req = 0; dmin = 10; dmax = 10;
      repeat (10) step();
      force_req[0] = 1'b1;
      repeat (3) step();
      force_req[1] = 1'b1;
      repeat (30) step();

      // Random traffic with stray valids and stray device readies.
      p_req = 35; dmin = 1; dmax = 6; garbage_en = 1'b1;
      repeat (3000) step();

      // Reset in WAIT with req1 pending: nothing must come out afterwards.
      p_req = 0; garbage_en = 1'b0; dmin = 8; dmax = 8;
      repeat (12) step();
      force_req[0] = 1'b1;
      step();
      step();
      force_req[1] = 1'b1;
      step();
      step();
      do_reset();
      repeat (10) step();

`ifdef PRINT_TIMEOUT_EN
      // Device never answers req0; req1 is served normally afterwards.
      do_reset();
      never = 1'b1;
      force_req[0] = 1'b1;
      step();
      step();
      never = 1'b0; dmin = 2; dmax = 2;
      force_req[1] = 1'b1;
      repeat (30) step();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
